// File: rtl/present_pkg.sv
// Shared PRESENT primitives: forward/inverse S-box tables, the bit permutation
// and its inverse, plus the FSM state type used by present_iter_core.
package present_pkg;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [2:0] {IDLE, KEYEXP, ROUND, DROUND, DONE} state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX[x];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  base;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      base = 6'(4 * n);
      y[base +: 4] = SBOX[x[base +: 4]];
    end
    return y;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  base;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      base = 6'(4 * n);
      y[base +: 4] = INV_SBOX[x[base +: 4]];
    end
    return y;
  endfunction

  // Bit j moves to position 16*j mod 63; bit 63 stays in place.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  src;
    logic [5:0]  dst;
    y = '0;
    for (int j = 0; j < 63; j++) begin
      src    = 6'(j);
      dst    = 6'((16 * j) % 63);
      y[dst] = x[src];
    end
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  src;
    logic [5:0]  dst;
    y = '0;
    for (int j = 0; j < 63; j++) begin
      src    = 6'(j);
      dst    = 6'((16 * j) % 63);
      y[src] = x[dst];
    end
    y[63] = x[63];
    return y;
  endfunction

endpackage

// File: rtl/present_key_schedule.sv
// Combinational PRESENT key schedule step for 80- or 128-bit keys.
// dir=0 gives update(key,round); dir=1 gives its inverse, invUpdate(key,round).
module present_key_schedule
  import present_pkg::*;
#(
  parameter int KEY_WIDTH = 80
) (
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [4:0]           round,
  input  logic                 dir,
  output logic [KEY_WIDTH-1:0] key_next
);

  logic [KEY_WIDTH-1:0] fwd;
  logic [KEY_WIDTH-1:0] inv;

  if (KEY_WIDTH == 80) begin : g_k80
    logic [79:0] rot;
    logic [79:0] unx;
    // NOTE: every always_comb output gets a full default first, so no latch is inferred.
    always_comb begin
      rot        = {key[18:0], key[79:19]};
      fwd        = rot;
      fwd[79:76] = sbox(rot[79:76]);
      fwd[19:15] = rot[19:15] ^ round;
      // Inverse undoes the steps in reverse order, then rotates right by 61.
      unx        = key;
      unx[19:15] = key[19:15] ^ round;
      unx[79:76] = inv_sbox(key[79:76]);
      inv        = {unx[60:0], unx[79:61]};
    end
  end else if (KEY_WIDTH == 128) begin : g_k128
    logic [127:0] rot;
    logic [127:0] unx;
    always_comb begin
      rot          = {key[66:0], key[127:67]};
      fwd          = rot;
      fwd[127:124] = sbox(rot[127:124]);
      fwd[123:120] = sbox(rot[123:120]);
      fwd[66:62]   = rot[66:62] ^ round;
      unx          = key;
      unx[66:62]   = key[66:62] ^ round;
      unx[127:124] = inv_sbox(key[127:124]);
      unx[123:120] = inv_sbox(key[123:120]);
      inv          = {unx[60:0], unx[127:61]};
    end
  end else begin : g_bad_key_width
    $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
  end

  assign key_next = dir ? inv : fwd;

endmodule

// File: rtl/present_iter_core.sv
// Iterative PRESENT cipher core, one round per clock, valid/ready on both sides.
// Defining PRESENT_DECRYPT_EN adds the inDecrypt port and the KEYEXP/DROUND decrypt path.
module present_iter_core
  import present_pkg::*;
#(
  parameter int KEY_WIDTH  = 80,
  parameter int NUM_ROUNDS = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [63:0]          inData,
  input  logic [KEY_WIDTH-1:0] inKey,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [63:0]          outData,
  output logic                 busy
`ifdef PRESENT_DECRYPT_EN
  ,
  input  logic                 inDecrypt
`endif
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_rounds
    $error("present_iter_core: NUM_ROUNDS must be in 1..31");
  end

  state_t               state;
  logic [63:0]          data;
  logic [KEY_WIDTH-1:0] key;
  logic [KEY_WIDTH-1:0] key_next;
  logic [4:0]           rnd;
  logic [63:0]          key_top;
  logic [63:0]          round_out;
  logic                 ks_dir;

  assign key_top   = key[KEY_WIDTH-1 -: 64];
  assign round_out = p_layer(sbox_layer(data ^ key_top));

`ifdef PRESENT_DECRYPT_EN
  logic [63:0] inv_round_out;
  assign inv_round_out = inv_sbox_layer(inv_p_layer(data ^ key_top));
  assign ks_dir        = (state == DROUND);
`else
  assign ks_dir = 1'b0;
`endif

  present_key_schedule #(
    .KEY_WIDTH (KEY_WIDTH)
  ) u_key_schedule (
    .key      (key),
    .round    (rnd),
    .dir      (ks_dir),
    .key_next (key_next)
  );

  assign inReady = (state == IDLE);
  assign busy    = (state != IDLE);

  // NOTE: all state here is plain flops, so every register is reset; an aborted
  // block leaves no trace of its plaintext or key behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data     <= '0;
      key      <= '0;
      rnd      <= '0;
      outValid <= 1'b0;
      outData  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (inValid) begin
            data <= inData;
            key  <= inKey;
            rnd  <= 5'd1;
`ifdef PRESENT_DECRYPT_EN
            state <= inDecrypt ? KEYEXP : ROUND;
`else
            state <= ROUND;
`endif
          end
        end

        ROUND: begin
          data <= round_out;
          key  <= key_next;
          // The last round folds in the final whitening key; the counter holds.
          if (rnd == LAST_ROUND) begin
            outData  <= round_out ^ key_next[KEY_WIDTH-1 -: 64];
            outValid <= 1'b1;
            state    <= DONE;
          end else begin
            rnd <= rnd + 5'd1;
          end
        end

`ifdef PRESENT_DECRYPT_EN
        KEYEXP: begin
          key <= key_next;
          if (rnd == LAST_ROUND) begin
            state <= DROUND;
          end else begin
            rnd <= rnd + 5'd1;
          end
        end

        DROUND: begin
          data <= inv_round_out;
          key  <= key_next;
          if (rnd == 5'd1) begin
            outData  <= inv_round_out ^ key_next[KEY_WIDTH-1 -: 64];
            outValid <= 1'b1;
            state    <= DONE;
          end else begin
            rnd <= rnd - 5'd1;
          end
        end
`endif

        DONE: begin
          if (outReady) begin
            outValid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_iter_core.sv
// Directed bench for present_iter_core: known-answer vectors for 80/128-bit keys,
// latency, backpressure, busy-ignore and mid-block reset (decrypt when PRESENT_DECRYPT_EN).
module tb_present_iter_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [63:0]  a_in_data, a_out_data;
  logic [79:0]  a_in_key;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [63:0]  b_in_data, b_out_data;
  logic [127:0] b_in_key;
`ifdef PRESENT_DECRYPT_EN
  logic         a_in_decrypt, b_in_decrypt;
`endif

  present_iter_core #(.KEY_WIDTH(80), .NUM_ROUNDS(31)) dut80 (
    .clk      (clk),
    .rst      (rst),
    .inValid  (a_in_valid),
    .inReady  (a_in_ready),
    .inData   (a_in_data),
    .inKey    (a_in_key),
    .outValid (a_out_valid),
    .outReady (a_out_ready),
    .outData  (a_out_data),
    .busy     (a_busy)
`ifdef PRESENT_DECRYPT_EN
    ,
    .inDecrypt(a_in_decrypt)
`endif
  );

  present_iter_core #(.KEY_WIDTH(128), .NUM_ROUNDS(31)) dut128 (
    .clk      (clk),
    .rst      (rst),
    .inValid  (b_in_valid),
    .inReady  (b_in_ready),
    .inData   (b_in_data),
    .inKey    (b_in_key),
    .outValid (b_out_valid),
    .outReady (b_out_ready),
    .outData  (b_out_data),
    .busy     (b_busy)
`ifdef PRESENT_DECRYPT_EN
    ,
    .inDecrypt(b_in_decrypt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one block to the selected core; returns #1 after the accepting edge.
  task automatic accept(input bit wide, input logic [63:0] d, input logic [127:0] k);
    int n = 0;
    while (!(wide ? b_in_ready : a_in_ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 64'(wide ? b_in_ready : a_in_ready), 64'd1);
    if (wide) begin
      b_in_valid = 1'b1; b_in_data = d; b_in_key = k;
    end else begin
      a_in_valid = 1'b1; a_in_data = d; a_in_key = k[79:0];
    end
    @(posedge clk); #1;
    // Scramble the inputs so the core must have latched them.
    a_in_valid = 1'b0; a_in_data = ~d; a_in_key = ~k[79:0];
    b_in_valid = 1'b0; b_in_data = ~d; b_in_key = ~k;
  endtask

  // Latency in cycles, counting the accept cycle as cycle 0.
  task automatic wait_out(input bit wide, output int lat);
    int n = 0;
    while (!(wide ? b_out_valid : a_out_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    lat = n + 1;
  endtask

  task automatic take(input bit wide, input string tag);
    if (wide) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    check({tag, "_in_ready_during_take"}, 64'(wide ? b_in_ready : a_in_ready), 64'd0);
    @(posedge clk); #1;
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    check({tag, "_out_valid_after_take"}, 64'(wide ? b_out_valid : a_out_valid), 64'd0);
    check({tag, "_in_ready_after_take"}, 64'(wide ? b_in_ready : a_in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_key = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_key = '0; b_out_ready = 1'b0;
`ifdef PRESENT_DECRYPT_EN
    a_in_decrypt = 1'b0; b_in_decrypt = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(a_out_valid), 64'd0);
    check("reset_out_data", a_out_data, 64'd0);
    check("reset_busy", 64'(a_busy), 64'd0);
    check("reset_in_ready", 64'(a_in_ready), 64'd1);
    check("reset_out_data_128", b_out_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero key / zero plaintext, with busy and latency checks.
    accept(1'b0, 64'h0, 128'h0);
    check("enc0_busy", 64'(a_busy), 64'd1);
    check("enc0_in_ready_busy", 64'(a_in_ready), 64'd0);
    wait_out(1'b0, lat);
    check("enc0_latency", 64'(lat), 64'd32);
    check("enc0_data", a_out_data, 64'h5579C1387B228445);
    take(1'b0, "enc0");

    accept(1'b0, 64'h0, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF});
    wait_out(1'b0, lat);
    check("enc_keyff_latency", 64'(lat), 64'd32);
    check("enc_keyff_data", a_out_data, 64'hE72C46C0F5945049);
    take(1'b0, "enc_keyff");

    accept(1'b0, 64'hFFFFFFFFFFFFFFFF, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF});
    wait_out(1'b0, lat);
    check("enc_ones_data", a_out_data, 64'h3333DCD3213210D2);
    take(1'b0, "enc_ones");

    accept(1'b1, 64'h0, 128'h0);
    check("enc128_busy", 64'(b_busy), 64'd1);
    wait_out(1'b1, lat);
    check("enc128_latency", 64'(lat), 64'd32);
    check("enc128_data", b_out_data, 64'h96DB702A2E6900AF);
    take(1'b1, "enc128");

    // Backpressure, with a competing block offered while busy.
    accept(1'b0, 64'h0, 128'h0);
    a_in_valid = 1'b1; a_in_data = 64'hDEADBEEFCAFEF00D; a_in_key = 80'h123456789ABCDEF01234;
    wait_out(1'b0, lat);
    check("bp_latency", 64'(lat), 64'd32);
    for (int c = 0; c < 10; c++) begin
      check("bp_out_valid", 64'(a_out_valid), 64'd1);
      check("bp_out_data", a_out_data, 64'h5579C1387B228445);
      check("bp_in_ready", 64'(a_in_ready), 64'd0);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    take(1'b0, "bp");

    // Reset in the middle of round 15 aborts the block.
    accept(1'b0, 64'h0123456789ABCDEF, {48'h0, 80'h0F1E2D3C4B5A69788796});
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(a_out_valid), 64'd0);
    check("abort_out_data", a_out_data, 64'd0);
    check("abort_busy", 64'(a_busy), 64'd0);
    check("abort_in_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    accept(1'b0, 64'h0, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF});
    wait_out(1'b0, lat);
    check("post_abort_latency", 64'(lat), 64'd32);
    check("post_abort_data", a_out_data, 64'hE72C46C0F5945049);
    take(1'b0, "post_abort");

`ifdef PRESENT_DECRYPT_EN
    a_in_decrypt = 1'b1;
    accept(1'b0, 64'h5579C1387B228445, 128'h0);
    a_in_decrypt = 1'b0;
    wait_out(1'b0, lat);
    check("dec_latency", 64'(lat), 64'd63);
    check("dec_data", a_out_data, 64'h0);
    take(1'b0, "dec");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
